// File: rtl/psk_acq_pkg.sv
// PSK acquisition scheduler: shared states, midpoint, magnitude helper.
// PSK_ACQ_CONFIRM_EN adds a confirmation dwell before lock.
package psk_acq_pkg;

`ifdef PSK_ACQ_CONFIRM_EN
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INTEGRATE,
    EVAL,
    CONFIRM
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INTEGRATE,
    EVAL
  } state_t;
`endif

  localparam int CORR_W_DEF = 8;
  localparam logic [31:0] MID = 32'd1 << (CORR_W_DEF - 1);

  function automatic logic [31:0] mag(
    input logic [31:0] i,
    input logic [31:0] q,
    input logic [31:0] mid = MID
  );
    logic [31:0] ai;
    logic [31:0] aq;
    ai = (i >= mid) ? i - mid : mid - i;
    aq = (q >= mid) ? q - mid : mid - q;
    return ai + aq;
  endfunction

endpackage

// File: rtl/psk_acq_if.sv
// Control/status bundle between the acquisition scheduler and
// the NCO/correlator datapath.
interface psk_acq_if #(
  parameter int FCW_W  = 13,
  parameter int CORR_W = 8,
  parameter int NBINS  = 16
);
  localparam int BW = (NBINS > 1) ? $clog2(NBINS) : 1;

  logic              start;
  logic              stop;
  logic [CORR_W-1:0] i_value;
  logic [CORR_W-1:0] q_value;
  logic              corr_rst;
  logic              stb;
  logic [FCW_W-1:0]  fcw;
  logic              locked;
  logic [BW-1:0]     best_bin;
  logic              sweep_fail;
  logic              busy;

  modport master (
    output start, stop, i_value, q_value,
    input  corr_rst, stb, fcw, locked,
    input  best_bin, sweep_fail, busy
  );

  modport slave (
    input  start, stop, i_value, q_value,
    output corr_rst, stb, fcw, locked,
    output best_bin, sweep_fail, busy
  );
endinterface

// File: rtl/psk_acq_ctl_dwell_timer.sv
// Dwell counter: holds correlators clear until go, then
// counts DWELL_LEN cycles and strobes the dump on the last one.
module acq_dwell_timer #(
  parameter int DWELL_LEN = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic corr_rst,
  output logic stb,
  output logic done
);
  localparam int CW = $clog2(DWELL_LEN);
  localparam logic [CW-1:0] LAST = CW'(DWELL_LEN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!go) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stb      = go && (cnt == LAST);
  assign done     = stb;
  assign corr_rst = !go;
endmodule

// File: rtl/psk_acq_ctl.sv
// Acquisition/tracking scheduler: sweeps NCO bins, scores dwells
// by |I|+|Q|, locks on the best bin, drops lock on repeated misses.
// Optional confirmation dwell: PSK_ACQ_CONFIRM_EN.
module psk_acq_ctl
  import psk_acq_pkg::*;
#(
  parameter int               FCW_W     = 13,
  parameter int               CORR_W    = CORR_W_DEF,
  parameter int               DWELL_LEN = 255,
  parameter int               NBINS     = 16,
  parameter logic [FCW_W-1:0] FCW_START = 13'h0200,
  parameter logic [FCW_W-1:0] FCW_STEP  = 13'h0040,
  parameter int               LOCK_THR  = 40,
  parameter int               LOSS_CNT  = 4
) (
  input logic     clk,
  input logic     rst,
  psk_acq_if.slave bus
);
  localparam int BW  = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int MW  = CORR_W + 1;
  localparam int MCW = $clog2(LOSS_CNT + 1);
  localparam logic [31:0]    MIDV = 32'd1 << (CORR_W - 1);
  localparam logic [BW-1:0]  LAST_BIN = BW'(NBINS - 1);
  localparam logic [MW-1:0]  THR = MW'(LOCK_THR);
  localparam logic [MCW-1:0] LOSS = MCW'(LOSS_CNT);

  state_t             state_q, state_d;
  logic [BW-1:0]      bin_q, bin_d;
  logic [FCW_W-1:0]   fcw_q, fcw_d;
  logic [MW-1:0]      best_q, best_d;
  logic [BW-1:0]      bbin_q, bbin_d;
  logic               lock_q, lock_d;
  logic [MCW-1:0]     miss_q, miss_d;
  logic               fail_q, fail_d;
  logic [CORR_W-1:0]  i_q, q_q;
  logic [MW-1:0]      mag_v;
  logic [MCW-1:0]     miss_n;
  logic               restart;
  logic               t_corr_rst, t_stb, t_done;
`ifdef PSK_ACQ_CONFIRM_EN
  logic               cfm_q, cfm_d;
`endif

  acq_dwell_timer #(.DWELL_LEN(DWELL_LEN)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .go       (state_q == INTEGRATE),
    .corr_rst (t_corr_rst),
    .stb      (t_stb),
    .done     (t_done)
  );

  assign mag_v = MW'(mag(32'(i_q), 32'(q_q), MIDV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      fcw_q   <= FCW_START;
      best_q  <= '0;
      bbin_q  <= '0;
      lock_q  <= 1'b0;
      miss_q  <= '0;
      fail_q  <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      fcw_q   <= fcw_d;
      best_q  <= best_d;
      bbin_q  <= bbin_d;
      lock_q  <= lock_d;
      miss_q  <= miss_d;
      fail_q  <= fail_d;
      if (t_stb) begin
        i_q <= bus.i_value;
        q_q <= bus.q_value;
      end
    end
  end

`ifdef PSK_ACQ_CONFIRM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfm_q <= 1'b0;
    else     cfm_q <= cfm_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    fcw_d   = fcw_q;
    best_d  = best_q;
    bbin_d  = bbin_q;
    lock_d  = lock_q;
    miss_d  = miss_q;
    fail_d  = 1'b0;
    miss_n  = '0;
    restart = 1'b0;
`ifdef PSK_ACQ_CONFIRM_EN
    cfm_d   = cfm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = CLEAR;
          restart = 1'b1;
        end
      end
      CLEAR: state_d = INTEGRATE;
      INTEGRATE: begin
        if (t_done) begin
`ifdef PSK_ACQ_CONFIRM_EN
          state_d = cfm_q ? CONFIRM : EVAL;
`else
          state_d = EVAL;
`endif
        end
      end
      EVAL: begin
        state_d = CLEAR;
        if (!lock_q) begin
          if (mag_v > best_q) begin
            best_d = mag_v;
            bbin_d = bin_q;
          end
          if (bin_q != LAST_BIN) begin
            bin_d = bin_q + 1'b1;
            fcw_d = fcw_q + FCW_STEP;
          end else if (best_d >= THR) begin
            fcw_d = FCW_START + FCW_W'(bbin_d) * FCW_STEP;
`ifdef PSK_ACQ_CONFIRM_EN
            cfm_d = 1'b1;
`else
            lock_d = 1'b1;
            miss_d = '0;
`endif
          end else begin
            fail_d  = 1'b1;
            restart = 1'b1;
          end
        end else begin
          miss_n = (mag_v < THR) ? miss_q + 1'b1 : '0;
          miss_d = miss_n;
          if (miss_n == LOSS) begin
            lock_d  = 1'b0;
            miss_d  = '0;
            restart = 1'b1;
          end
        end
      end
`ifdef PSK_ACQ_CONFIRM_EN
      CONFIRM: begin
        state_d = CLEAR;
        cfm_d   = 1'b0;
        if (mag_v >= THR) begin
          lock_d = 1'b1;
          miss_d = '0;
        end else begin
          fail_d  = 1'b1;
          restart = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (restart) begin
      bin_d  = '0;
      fcw_d  = FCW_START;
      best_d = '0;
      bbin_d = '0;
    end

    // abort keeps the datapath settings, only drops lock
    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      bin_d   = bin_q;
      fcw_d   = fcw_q;
      best_d  = best_q;
      bbin_d  = bbin_q;
      miss_d  = miss_q;
      lock_d  = 1'b0;
      fail_d  = 1'b0;
`ifdef PSK_ACQ_CONFIRM_EN
      cfm_d   = 1'b0;
`endif
    end
  end

  assign bus.corr_rst   = t_corr_rst;
  assign bus.stb        = t_stb;
  assign bus.fcw        = fcw_q;
  assign bus.locked     = lock_q;
  assign bus.best_bin   = bbin_q;
  assign bus.sweep_fail = fail_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_psk_acq_ctl.sv
// Directed bench for psk_acq_ctl: expected fcw per dwell is queued
// before each sweep and popped at every dump strobe.
module tb_psk_acq_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [12:0] exp_q[$];
  int stb_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  psk_acq_if #(.FCW_W(13), .CORR_W(8), .NBINS(4)) bus_a ();
  psk_acq_if #(.FCW_W(13), .CORR_W(8), .NBINS(4)) bus_b ();

  psk_acq_ctl #(
    .FCW_W(13), .CORR_W(8), .DWELL_LEN(8), .NBINS(4),
    .FCW_START(13'h0200), .FCW_STEP(13'h0040),
    .LOCK_THR(40), .LOSS_CNT(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  psk_acq_ctl #(
    .FCW_W(13), .CORR_W(8), .DWELL_LEN(8), .NBINS(4),
    .FCW_START(13'h1FC0), .FCW_STEP(13'h0040),
    .LOCK_THR(40), .LOSS_CNT(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_dut(input int sel);
    if (sel == 0) bus_a.start = 1'b1;
    else          bus_b.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic stop_dut(input int sel);
    if (sel == 0) bus_a.stop = 1'b1;
    else          bus_b.stop = 1'b1;
    @(negedge clk);
    bus_a.stop = 1'b0;
    bus_b.stop = 1'b0;
    check("stop_busy", sel == 0 ? bus_a.busy : bus_b.busy, 0);
    check("stop_locked", sel == 0 ? bus_a.locked : bus_b.locked, 0);
  endtask

  // returns at the EVAL cycle, after I/Q have been captured
  task automatic dwell(input int sel, input int iv, input int qv);
    bit seen;
    logic [12:0] e;
    seen = 1'b0;
    bus_a.i_value = 8'(iv);
    bus_a.q_value = 8'(qv);
    bus_b.i_value = 8'(iv);
    bus_b.q_value = 8'(qv);
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if ((sel == 0) ? bus_a.stb : bus_b.stb) seen = 1'b1;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
    if (!seen) begin
      check("stb_timeout", 0, 1);
    end else begin
      stb_t.push_back(cyc_cnt);
      check("dwell_fcw", sel == 0 ? bus_a.fcw : bus_b.fcw, e);
      @(negedge clk);
    end
  endtask

  initial begin
    bit stb_seen;
    bit busy_seen;
    bus_a.start = 1'b0; bus_a.stop = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0;
    bus_a.i_value = 8'd128; bus_a.q_value = 8'd128;
    bus_b.i_value = 8'd128; bus_b.q_value = 8'd128;
    repeat (3) @(negedge clk);
    check("rst_corr_rst", bus_a.corr_rst, 1);
    check("rst_stb", bus_a.stb, 0);
    check("rst_fcw", bus_a.fcw, 13'h200);
    check("rst_locked", bus_a.locked, 0);
    check("rst_best_bin", bus_a.best_bin, 0);
    check("rst_sweep_fail", bus_a.sweep_fail, 0);
    check("rst_busy", bus_a.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // async reset in the middle of bin 2
    exp_q.push_back(13'h200);
    exp_q.push_back(13'h240);
    start_dut(0);
    dwell(0, 138, 128);
    dwell(0, 148, 128);
    repeat (3) @(negedge clk);
    check("mid_fcw", bus_a.fcw, 13'h280);
    #3 rst = 1'b1;
    #1;
    check("arst_corr_rst", bus_a.corr_rst, 1);
    check("arst_stb", bus_a.stb, 0);
    check("arst_locked", bus_a.locked, 0);
    check("arst_fcw", bus_a.fcw, 13'h200);
    check("arst_busy", bus_a.busy, 0);
    check("arst_fail", bus_a.sweep_fail, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // strong bin 2, then tracking and loss of lock
    stb_t.delete();
    exp_q.push_back(13'h200);
    exp_q.push_back(13'h240);
    exp_q.push_back(13'h280);
    exp_q.push_back(13'h2C0);
    start_dut(0);
    dwell(0, 128, 118);
    dwell(0, 148, 128);
    dwell(0, 228, 128);
    dwell(0, 113, 143);
    for (int k = 1; k < 4; k++)
      check("stb_spacing", stb_t[k] - stb_t[k-1], 10);
    @(negedge clk);
    check("lock_locked", bus_a.locked, 1);
    check("lock_best_bin", bus_a.best_bin, 2);
    check("lock_fcw", bus_a.fcw, 13'h280);
    repeat (8) exp_q.push_back(13'h280);
    repeat (3) dwell(0, 133, 128);
    dwell(0, 228, 128);
    @(negedge clk);
    check("hold_locked", bus_a.locked, 1);
    repeat (3) dwell(0, 128, 123);
    @(negedge clk);
    check("miss3_locked", bus_a.locked, 1);
    dwell(0, 133, 128);
    @(negedge clk);
    check("loss_locked", bus_a.locked, 0);
    check("loss_fcw", bus_a.fcw, 13'h200);
    check("loss_no_fail", bus_a.sweep_fail, 0);
    check("loss_busy", bus_a.busy, 1);
    exp_q.push_back(13'h200);
    dwell(0, 138, 128);
    stop_dut(0);

    // no signal: sweep fails and repeats
    exp_q.push_back(13'h200);
    exp_q.push_back(13'h240);
    exp_q.push_back(13'h280);
    exp_q.push_back(13'h2C0);
    exp_q.push_back(13'h200);
    start_dut(0);
    repeat (4) dwell(0, 138, 128);
    @(negedge clk);
    check("fail_pulse", bus_a.sweep_fail, 1);
    check("fail_fcw", bus_a.fcw, 13'h200);
    check("fail_locked", bus_a.locked, 0);
    @(negedge clk);
    check("fail_one_cycle", bus_a.sweep_fail, 0);
    dwell(0, 138, 128);
    stop_dut(0);

    // tie between bins 1 and 3 keeps the lower bin
    exp_q.push_back(13'h200);
    exp_q.push_back(13'h240);
    exp_q.push_back(13'h280);
    exp_q.push_back(13'h2C0);
    start_dut(0);
    dwell(0, 138, 128);
    dwell(0, 218, 128);
    dwell(0, 148, 128);
    dwell(0, 128, 38);
    @(negedge clk);
    check("tie_locked", bus_a.locked, 1);
    check("tie_best_bin", bus_a.best_bin, 1);
    check("tie_fcw", bus_a.fcw, 13'h240);
    stop_dut(0);

    // fcw wrap on the second instance
    exp_q.push_back(13'h1FC0);
    exp_q.push_back(13'h0000);
    start_dut(1);
    dwell(1, 138, 128);
    dwell(1, 138, 128);
    stop_dut(1);

    // stop and start together mid-integrate
    start_dut(0);
    repeat (2) @(negedge clk);
    bus_a.stop = 1'b1;
    bus_a.start = 1'b1;
    @(negedge clk);
    check("ss_busy", bus_a.busy, 0);
    check("ss_corr_rst", bus_a.corr_rst, 1);
    bus_a.stop = 1'b0;
    bus_a.start = 1'b0;
    stb_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus_a.stb) stb_seen = 1'b1;
      if (bus_a.busy) busy_seen = 1'b1;
    end
    check("ss_no_stb", stb_seen, 0);
    check("ss_stay_idle", busy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
